// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM dead-time driver.
package pwm_pkg;

  localparam int unsigned DtWDefault  = 8;
  localparam int unsigned CntWDefault = 8;

  // Gate driver FSM states
  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StDtHs  = 3'd1,
    StHsOn  = 3'd2,
    StDtLs  = 3'd3,
    StLsOn  = 3'd4,
    StFault = 3'd5
  } pwm_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  // Metastability chain: first flop may go metastable, second settles it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary half-bridge driver: dead-time insertion, narrow-pulse filter,
// latched fault shutdown.
module pwm_deadtime_driver
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W  = DtWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  input  logic [DT_W-1:0]  dead_time,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             hs_out,
  output logic             ls_out,
  output logic             fault_latched,
  output logic [CNT_W-1:0] filt_cnt
);

  pwm_state_e        state_q, state_d;
  logic [DT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  filt_q, filt_d;
  logic              pwm_q;
  logic              fault_s;
  logic              filt_inc;
  logic              hs_q, hs_d;
  logic              ls_q, ls_d;
  logic              flt_q, flt_d;
  logic [DT_W-1:0]   dt_load;

  sync_2ff #(
    .Width (1)
  ) u_fault_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (fault_in),
    .q_o   (fault_s)
  );

  // A zero dead time still guarantees one both-off cycle
  assign dt_load = (dead_time == '0) ? DT_W'(1) : dead_time;

  // State, counters and registered gate outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      dcnt_q  <= '0;
      filt_q  <= '0;
      pwm_q   <= 1'b0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      filt_q  <= filt_d;
      pwm_q   <= pwm_in;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      flt_q   <= flt_d;
    end
  end

  // Next-state, dead counter and filter counter update
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    filt_inc = 1'b0;

    if (fault_s) begin
      // Fault overrides enable, PWM and any pending clear
      state_d = StFault;
      dcnt_d  = '0;
    end else if (state_q == StFault) begin
      if (fault_clr) begin
        state_d = StOff;
      end
    end else if (!ena) begin
      state_d = StOff;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = pwm_q ? StDtHs : StDtLs;
          dcnt_d  = dt_load;
        end
        StDtHs: begin
          if (!pwm_q) begin
            // Request reversed before the gap expired: swallow the pulse
            state_d  = StDtLs;
            dcnt_d   = dt_load;
            filt_inc = 1'b1;
          end else if (dcnt_q <= DT_W'(1)) begin
            state_d = StHsOn;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - DT_W'(1);
          end
        end
        StDtLs: begin
          if (pwm_q) begin
            state_d  = StDtHs;
            dcnt_d   = dt_load;
            filt_inc = 1'b1;
          end else if (dcnt_q <= DT_W'(1)) begin
            state_d = StLsOn;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - DT_W'(1);
          end
        end
        StHsOn: begin
          if (!pwm_q) begin
            state_d = StDtLs;
            dcnt_d  = dt_load;
          end
        end
        StLsOn: begin
          if (pwm_q) begin
            state_d = StDtHs;
            dcnt_d  = dt_load;
          end
        end
        default: begin
          state_d = StOff;
          dcnt_d  = '0;
        end
      endcase
    end

    filt_d = (filt_inc && (filt_q != '1)) ? filt_q + CNT_W'(1) : filt_q;
  end

  // Gate enables decoded from the next state so they change with the state
  always_comb begin
    hs_d  = (state_d == StHsOn);
    ls_d  = (state_d == StLsOn);
    flt_d = (state_d == StFault);
  end

  assign hs_out        = hs_q;
  assign ls_out        = ls_q;
  assign fault_latched = flt_q;
  assign filt_cnt      = filt_q;

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Scoreboard bench for pwm_deadtime_driver: expected gate/fault/filter values
// are queued with the cycle they must appear in and compared when it arrives.
module tb_pwm_deadtime_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       fault_in;
  logic       fault_clr;
  logic       hs_out;
  logic       ls_out;
  logic       fault_latched;
  logic [7:0] filt_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;

  int unsigned q_at[$];
  string       q_tag[$];
  logic [10:0] q_val[$];

  logic        gap_en    = 1'b0;
  int unsigned last_side = 0;
  int unsigned low_cnt   = 0;

  pwm_deadtime_driver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .fault_in      (fault_in),
    .fault_clr     (fault_clr),
    .hs_out        (hs_out),
    .ls_out        (ls_out),
    .fault_latched (fault_latched),
    .filt_cnt      (filt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int unsigned at, input string tag, input logic hs,
                          input logic ls, input logic flt, input logic [7:0] filt);
    q_at.push_back(at);
    q_tag.push_back(tag);
    q_val.push_back({hs, ls, flt, filt});
  endtask

  task automatic to_cycle(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    int unsigned at;
    string       tag;
    logic [10:0] v;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      check_eq("overlap", {31'b0, hs_out & ls_out}, 32'd0);
      if (!rst_n) begin
        last_side = 0;
        low_cnt   = 0;
      end else if (hs_out) begin
        if (gap_en && last_side == 2) check_eq("dead_gap_hs", {31'b0, low_cnt >= 3}, 32'd1);
        last_side = 1;
        low_cnt   = 0;
      end else if (ls_out) begin
        if (gap_en && last_side == 1) check_eq("dead_gap_ls", {31'b0, low_cnt >= 3}, 32'd1);
        last_side = 2;
        low_cnt   = 0;
      end else begin
        low_cnt++;
      end
      while (q_at.size() != 0 && q_at[0] <= cyc) begin
        at  = q_at.pop_front();
        tag = q_tag.pop_front();
        v   = q_val.pop_front();
        check_eq(tag, {21'b0, hs_out, ls_out, fault_latched, filt_cnt}, {21'b0, v});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int unsigned d;
    logic [7:0]  f;
    logic [7:0]  fn;

    rst_n     = 1'b0;
    ena       = 1'b0;
    pwm_in    = 1'b0;
    dead_time = 8'd3;
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_hs", {31'b0, hs_out}, 32'd0);
    check_eq("rst_ls", {31'b0, ls_out}, 32'd0);
    check_eq("rst_flt", {31'b0, fault_latched}, 32'd0);
    check_eq("rst_filt", {24'b0, filt_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Entry from OFF into low side with dead_time 3
    c = cyc;
    ena = 1'b1;
    pwm_in = 1'b0;
    dead_time = 8'd3;
    for (int i = 1; i <= 3; i++) push_exp(c + i, "entry_dead", 0, 0, 0, 8'd0);
    push_exp(c + 4, "entry_ls_on", 0, 1, 0, 8'd0);
    to_cycle(c + 6);

    // LS -> HS with dead_time 4
    c = cyc;
    dead_time = 8'd4;
    pwm_in = 1'b1;
    push_exp(c + 1, "ls2hs_hold", 0, 1, 0, 8'd0);
    for (int i = 2; i <= 5; i++) push_exp(c + i, "ls2hs_dead", 0, 0, 0, 8'd0);
    push_exp(c + 6, "ls2hs_hs_on", 1, 0, 0, 8'd0);
    to_cycle(c + 8);

    // dead_time 0 behaves as a single both-off cycle, both directions
    c = cyc;
    dead_time = 8'd0;
    pwm_in = 1'b0;
    push_exp(c + 1, "dt0_hold", 1, 0, 0, 8'd0);
    push_exp(c + 2, "dt0_dead", 0, 0, 0, 8'd0);
    push_exp(c + 3, "dt0_ls_on", 0, 1, 0, 8'd0);
    to_cycle(c + 4);
    c = cyc;
    pwm_in = 1'b1;
    push_exp(c + 1, "dt0b_hold", 0, 1, 0, 8'd0);
    push_exp(c + 2, "dt0b_dead", 0, 0, 0, 8'd0);
    push_exp(c + 3, "dt0b_hs_on", 1, 0, 0, 8'd0);
    to_cycle(c + 4);

    // Back to LS_ON with dead_time 5
    c = cyc;
    dead_time = 8'd5;
    pwm_in = 1'b0;
    push_exp(c + 6, "back_dead", 0, 0, 0, 8'd0);
    push_exp(c + 7, "back_ls_on", 0, 1, 0, 8'd0);
    to_cycle(c + 9);

    // Narrow 2-cycle high pulses get swallowed; counter saturates
    f = 8'd0;
    for (int k = 0; k < 300; k++) begin
      c = cyc;
      pwm_in = 1'b1;
      fn = (f == 8'hff) ? f : f + 8'd1;
      push_exp(c + 1, "filt_hold", 0, 1, 0, f);
      push_exp(c + 2, "filt_dt_hs", 0, 0, 0, f);
      push_exp(c + 3, "filt_dt_hs", 0, 0, 0, f);
      for (int i = 4; i <= 8; i++) push_exp(c + i, "filt_dt_ls", 0, 0, 0, fn);
      push_exp(c + 9, "filt_ls_back", 0, 1, 0, fn);
      to_cycle(c + 2);
      pwm_in = 1'b0;
      to_cycle(c + 10);
      f = fn;
    end
    check_eq("filt_saturated", {24'b0, filt_cnt}, 32'd255);

    // ena low forces OFF; re-enable with pwm high enters via DT_HS
    c = cyc;
    ena = 1'b0;
    pwm_in = 1'b1;
    push_exp(c + 1, "ena_off", 0, 0, 0, 8'hff);
    to_cycle(c + 2);
    c = cyc;
    ena = 1'b1;
    for (int i = 1; i <= 5; i++) push_exp(c + i, "reena_dead", 0, 0, 0, 8'hff);
    push_exp(c + 6, "reena_hs_on", 1, 0, 0, 8'hff);
    to_cycle(c + 8);

    // Asynchronous fault from HS_ON
    c = cyc;
    #2;
    fault_in = 1'b1;
    push_exp(c + 1, "flt_sync1", 1, 0, 0, 8'hff);
    push_exp(c + 2, "flt_sync2", 1, 0, 0, 8'hff);
    push_exp(c + 3, "flt_gates_off", 0, 0, 1, 8'hff);
    to_cycle(c + 4);
    d = cyc;
    fault_clr = 1'b1;
    for (int i = 1; i <= 5; i++) push_exp(d + i, "flt_held", 0, 0, 1, 8'hff);
    to_cycle(d + 1);
    fault_clr = 1'b0;
    to_cycle(d + 2);
    fault_in = 1'b0;
    to_cycle(d + 5);
    fault_clr = 1'b1;
    dead_time = 8'd2;
    push_exp(d + 6, "flt_cleared", 0, 0, 0, 8'hff);
    push_exp(d + 7, "flt_re_dead", 0, 0, 0, 8'hff);
    push_exp(d + 8, "flt_re_dead", 0, 0, 0, 8'hff);
    push_exp(d + 9, "flt_re_hs_on", 1, 0, 0, 8'hff);
    to_cycle(d + 6);
    fault_clr = 1'b0;
    to_cycle(d + 11);

    // Random pwm/ena/dead_time with minimum dead gap of 3 enforced
    ena = 1'b0;
    dead_time = 8'd3;
    to_cycle(cyc + 2);
    gap_en = 1'b1;
    last_side = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) dead_time = 8'($urandom_range(3, 12));
      if ($urandom_range(0, 3) == 0) pwm_in = ~pwm_in;
      ena = ($urandom_range(0, 31) != 0);
      @(negedge clk);
    end
    gap_en = 1'b0;

    // Reset asserted in the middle of DT_HS
    ena = 1'b1;
    pwm_in = 1'b0;
    dead_time = 8'd1;
    c = cyc;
    push_exp(c + 19, "pre_rst_ls_on", 0, 1, 0, 8'hff);
    to_cycle(c + 20);
    c = cyc;
    dead_time = 8'd10;
    pwm_in = 1'b1;
    push_exp(c + 1, "pre_rst_hold", 0, 1, 0, 8'hff);
    push_exp(c + 4, "pre_rst_dt_hs", 0, 0, 0, 8'hff);
    to_cycle(c + 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_hs", {31'b0, hs_out}, 32'd0);
    check_eq("midrst_ls", {31'b0, ls_out}, 32'd0);
    check_eq("midrst_flt", {31'b0, fault_latched}, 32'd0);
    check_eq("midrst_filt", {24'b0, filt_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    to_cycle(cyc + 3);

    check_eq("queue_drain", q_at.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
